// File: rtl/alu_sout_tx.sv
// alu_sout_tx - serial result transmitter driving the ALU sout pin.
//
// Takes one result per valid/ready handshake and shifts it out as 11-bit
// packets: start(0), type(0=data,1=ctl), d[7]..d[0], stop(1).
// A good result is four data packets (C MSB byte first) followed by a ctl
// packet {0, flags, crc3}. An error result is a single ctl packet
// {1, err_flags, parity}. After the final stop bit the line idles for GAP
// cycles before ready re-asserts.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset
//   valid      in   result request, held until accepted
//   ready      out  high while idle
//   err        in   1 = error frame, 0 = good frame
//   C          in   32-bit result word (good frame)
//   flags      in   4-bit ALU flags (good frame)
//   crc3       in   3-bit result CRC (good frame)
//   err_flags  in   6-bit error flags (error frame)
//   parity     in   error parity bit (error frame)
//   sout       out  registered serial line, idles at 1
//   done       out  one-cycle pulse after the final stop bit
//
// state | meaning
// IDLE  | line at 1, ready high, waiting for valid
// SEND  | shifting packets; bit_cnt_q is the bit currently on the line
// GAP   | post-frame idle, gap_cnt_q counts down to 1

module alu_sout_tx #(
    parameter int unsigned GAP = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid,
    output logic        ready,
    input  logic        err,
    input  logic [31:0] C,
    input  logic [3:0]  flags,
    input  logic [2:0]  crc3,
    input  logic [5:0]  err_flags,
    input  logic        parity,
    output logic        sout,
    output logic        done
);

    localparam logic [3:0] GAP_CNT = 4'(GAP);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]  pkt_cnt_q, pkt_cnt_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;
    logic        sout_q, sout_d;
    logic        done_q, done_d;

    logic        err_q, err_d;
    logic [31:0] c_q, c_d;
    logic [3:0]  flags_q, flags_d;
    logic [2:0]  crc3_q, crc3_d;
    logic [5:0]  err_flags_q, err_flags_d;
    logic        parity_q, parity_d;

    logic        last_pkt;
    logic        pkt_type;
    logic [7:0]  pkt_byte;
    logic [3:0]  nxt_bit;
    logic        nxt_val;

    // Payload of the packet currently being shifted.
    always_comb begin
        pkt_byte = {1'b0, flags_q, crc3_q};
        if (err_q) begin
            pkt_byte = {1'b1, err_flags_q, parity_q};
        end else begin
            case (pkt_cnt_q)
                3'd0:    pkt_byte = c_q[31:24];
                3'd1:    pkt_byte = c_q[23:16];
                3'd2:    pkt_byte = c_q[15:8];
                3'd3:    pkt_byte = c_q[7:0];
                default: pkt_byte = {1'b0, flags_q, crc3_q};
            endcase
        end
    end

    assign last_pkt = err_q ? (pkt_cnt_q == 3'd0) : (pkt_cnt_q == 3'd4);
    assign pkt_type = err_q | (pkt_cnt_q == 3'd4);

    // Value of the following bit inside the current packet (indices 1..10).
    assign nxt_bit = bit_cnt_q + 4'd1;
    always_comb begin
        case (nxt_bit)
            4'd1:    nxt_val = pkt_type;
            4'd10:   nxt_val = 1'b1;
            default: nxt_val = pkt_byte[3'(4'd9 - nxt_bit)];
        endcase
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        pkt_cnt_d   = pkt_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        sout_d      = sout_q;
        done_d      = 1'b0;
        err_d       = err_q;
        c_d         = c_q;
        flags_d     = flags_q;
        crc3_d      = crc3_q;
        err_flags_d = err_flags_q;
        parity_d    = parity_q;

        case (state_q)
            S_IDLE: begin
                sout_d = 1'b1;
                if (valid) begin
                    err_d       = err;
                    c_d         = C;
                    flags_d     = flags;
                    crc3_d      = crc3;
                    err_flags_d = err_flags;
                    parity_d    = parity;
                    state_d     = S_SEND;
                    bit_cnt_d   = 4'd0;
                    pkt_cnt_d   = 3'd0;
                    sout_d      = 1'b0;
                end
            end
            S_SEND: begin
                if (bit_cnt_q == 4'd10) begin
                    bit_cnt_d = 4'd0;
                    if (last_pkt) begin
                        sout_d    = 1'b1;
                        done_d    = 1'b1;
                        pkt_cnt_d = 3'd0;
                        if (GAP == 0) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d   = S_GAP;
                            gap_cnt_d = GAP_CNT;
                        end
                    end else begin
                        // Next packet starts immediately, no idle bit.
                        pkt_cnt_d = pkt_cnt_q + 3'd1;
                        sout_d    = 1'b0;
                    end
                end else begin
                    bit_cnt_d = nxt_bit;
                    sout_d    = nxt_val;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == 4'd1) begin
                    gap_cnt_d = 4'd0;
                    state_d   = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= 4'd0;
            pkt_cnt_q   <= 3'd0;
            gap_cnt_q   <= 4'd0;
            sout_q      <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            c_q         <= 32'd0;
            flags_q     <= 4'd0;
            crc3_q      <= 3'd0;
            err_flags_q <= 6'd0;
            parity_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            pkt_cnt_q   <= pkt_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            sout_q      <= sout_d;
            done_q      <= done_d;
            err_q       <= err_d;
            c_q         <= c_d;
            flags_q     <= flags_d;
            crc3_q      <= crc3_d;
            err_flags_q <= err_flags_d;
            parity_q    <= parity_d;
        end
    end

    assign ready = (state_q == S_IDLE);
    assign sout  = sout_q;
    assign done  = done_q;

endmodule

// File: tb/tb_alu_sout_tx.sv
// Bench for alu_sout_tx: a frame-level model predicts sout/done/ready for
// every cycle from the accept time and the packet rules; a negedge process
// compares the DUT against it. Literal checks pin the model and the
// captured bit streams.

module tb_alu_sout_tx;

    localparam int GAP = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic        ready;
    logic        err;
    logic [31:0] C;
    logic [3:0]  flags;
    logic [2:0]  crc3;
    logic [5:0]  err_flags;
    logic        parity;
    logic        sout;
    logic        done;

    always #5 clk = ~clk;

    alu_sout_tx #(.GAP(GAP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid     (valid),
        .ready     (ready),
        .err       (err),
        .C         (C),
        .flags     (flags),
        .crc3      (crc3),
        .err_flags (err_flags),
        .parity    (parity),
        .sout      (sout),
        .done      (done)
    );

    int vectors     = 0;
    int miscompares = 0;

    // ---------------- model ----------------
    function automatic logic [10:0] pkt(input logic typ, input logic [7:0] d);
        return {1'b0, typ, d, 1'b1};
    endfunction

    function automatic logic [63:0] frame_vec(input logic e, input logic [31:0] c,
                                              input logic [3:0] f, input logic [2:0] cr,
                                              input logic [5:0] ef, input logic par);
        if (e) return {53'd0, pkt(1'b1, {1'b1, ef, par})};
        return {9'd0, pkt(1'b0, c[31:24]), pkt(1'b0, c[23:16]), pkt(1'b0, c[15:8]),
                pkt(1'b0, c[7:0]), pkt(1'b1, {1'b0, f, cr})};
    endfunction

    bit          m_live = 0;
    bit          m_in_frame = 0;
    int          m_k = 0;
    int          m_len = 0;
    logic [63:0] m_vec = '0;
    logic        m_sout = 1'b1, m_done = 1'b0, m_ready = 1'b1;
    int          acc_cnt = 0;
    int          acc_cyc = 0;
    int          cyc = 0;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_live = 1; m_in_frame = 0;
            m_sout = 1'b1; m_done = 1'b0; m_ready = 1'b1;
        end else begin
            if (m_ready && valid) begin
                m_in_frame = 1; m_k = 0;
                m_vec = frame_vec(err, C, flags, crc3, err_flags, parity);
                m_len = err ? 11 : 55;
                acc_cnt++; acc_cyc = cyc;
            end else if (m_in_frame) begin
                m_k++;
            end
            if (m_in_frame) begin
                m_sout  = (m_k < m_len) ? m_vec[m_len-1-m_k] : 1'b1;
                m_done  = (m_k == m_len);
                m_ready = (m_k >= m_len + GAP);
                if (m_ready) m_in_frame = 0;
            end else begin
                m_sout = 1'b1; m_done = 1'b0; m_ready = 1'b1;
            end
        end
    end

    // ---------------- compare ----------------
    logic [63:0] cap = '0;
    int          done_k = -1;

    always @(negedge clk) begin
        if (m_live) begin
            vectors++;
            if ({sout, done, ready} !== {m_sout, m_done, m_ready}) begin
                miscompares++;
                $display("FAIL cycle%0d sout/done/ready: got %b%b%b expected %b%b%b",
                         cyc, sout, done, ready, m_sout, m_done, m_ready);
            end
            if (m_in_frame && m_k < m_len) begin
                if (m_k == 0) begin
                    cap    = 64'(sout);
                    done_k = -1;
                end else begin
                    cap = {cap[62:0], sout};
                end
            end
            if (done === 1'b1) done_k = m_k;
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic set_in(input logic e, input logic [31:0] c, input logic [3:0] f,
                          input logic [2:0] cr, input logic [5:0] ef, input logic par);
        err = e; C = c; flags = f; crc3 = cr; err_flags = ef; parity = par;
    endtask

    task automatic wait_accept(input int n0);
        int i;
        for (i = 0; i < 300; i++) begin
            @(negedge clk);
            if (acc_cnt != n0) break;
        end
        if (i == 300) check("accept_timeout", 64'(acc_cnt), 64'(n0 + 1));
    endtask

    task automatic send(input logic e, input logic [31:0] c, input logic [3:0] f,
                        input logic [2:0] cr, input logic [5:0] ef, input logic par);
        int n0;
        set_in(e, c, f, cr, ef, par);
        n0 = acc_cnt;
        valid = 1'b1;
        wait_accept(n0);
        valid = 1'b0;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!m_in_frame) break;
        end
        if (i == 300) check("idle_timeout", 64'd1, 64'd0);
        repeat (2) @(negedge clk);
    endtask

    localparam logic [63:0] GOOD_LIT = {9'd0, 11'b00000100101, 11'b00001101001,
                                        11'b00010101101, 11'b00011110001, 11'b01010101011};
    localparam logic [63:0] ERR_LIT  = {53'd0, 11'b01110010011};
    localparam logic [63:0] ERR2_LIT = {53'd0, 11'b01101001101};
    localparam logic [63:0] A5_LIT   = {9'd0, 11'b00000000001, 11'b00000000001,
                                        11'b00000000001, 11'b00101001011, 11'b01000000001};

    initial begin
        int a1, a2, n0;
        rst_n = 1'b0; valid = 1'b0;
        set_in(1'b0, 32'd0, 4'd0, 3'd0, 6'd0, 1'b0);
        repeat (2) @(negedge clk);
        check("reset_sout",  64'(sout),  64'd1);
        check("reset_ready", 64'(ready), 64'd1);
        check("reset_done",  64'(done),  64'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        check("model_good", frame_vec(1'b0, 32'h12345678, 4'b1010, 3'b101, 6'd0, 1'b0), GOOD_LIT);
        check("model_err",  frame_vec(1'b1, 32'd0, 4'd0, 3'd0, 6'b100100, 1'b1), ERR_LIT);

        // good frame
        send(1'b0, 32'h12345678, 4'b1010, 3'b101, 6'd0, 1'b0);
        wait_idle();
        check("good_stream", cap, GOOD_LIT);
        check("good_done_k", 64'(done_k), 64'd55);

        // error frame
        send(1'b1, 32'h0, 4'd0, 3'd0, 6'b100100, 1'b1);
        wait_idle();
        check("err_stream", cap, ERR_LIT);
        check("err_done_k", 64'(done_k), 64'd11);

        // back-to-back with valid held high
        set_in(1'b0, 32'h11223344, 4'b0001, 3'b010, 6'd0, 1'b0);
        n0 = acc_cnt;
        valid = 1'b1;
        wait_accept(n0);
        a1 = acc_cyc;
        set_in(1'b0, 32'hDEADBEEF, 4'b1111, 3'b111, 6'd0, 1'b0);
        wait_accept(n0 + 1);
        a2 = acc_cyc;
        valid = 1'b0;
        check("b2b_spacing", 64'(a2 - a1), 64'd58);
        wait_idle();

        // reset during packet 2, bit 5 (edge E0+27)
        send(1'b0, 32'hCAFEF00D, 4'b0110, 3'b011, 6'd0, 1'b0);
        repeat (26) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_sout",  64'(sout),  64'd1);
        check("midrst_ready", 64'(ready), 64'd1);
        check("midrst_done",  64'(done),  64'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        send(1'b1, 32'h0, 4'd0, 3'd0, 6'b010011, 1'b0);
        wait_idle();
        check("post_rst_err_stream", cap, ERR2_LIT);
        check("post_rst_done_k", 64'(done_k), 64'd11);

        // input stability and busy valid pulse
        n0 = acc_cnt;
        send(1'b0, 32'h000000A5, 4'd0, 3'd0, 6'd0, 1'b0);
        @(negedge clk);
        C = 32'hFFFFFFFF;
        repeat (5) @(negedge clk);
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        wait_idle();
        check("stable_stream", cap, A5_LIT);
        check("busy_valid_ignored", 64'(acc_cnt - n0), 64'd1);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1);
    end

endmodule
